// File: rtl/mvu_pkg.sv
// Shared definitions for the MVU memory-side blocks.
//   - Default RAM geometry (address width, word width, length-field width).
//   - Read-streamer FSM state encodings.
package mvu_pkg;

  localparam int BDADDR_DEF = 12;
  localparam int BDWORD_DEF = 32 * 64;
  // One extra bit so a full 2**BDADDR sweep fits in the length field.
  localparam int BDLEN_DEF  = BDADDR_DEF + 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that soaks up the one-cycle RAM read latency under backpressure.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears occupancy only)
//   push, din  write one word (caller guarantees no push when full without pop)
//   pop        remove head (caller guarantees occ != 0)
//   dout       head word, meaningful while occ != 0
//   occ        number of stored words, 0..2
module skid_fifo2 #(
  parameter int BDWORD = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BDWORD-1:0] din,
  input  logic              pop,
  output logic [BDWORD-1:0] dout,
  output logic [1:0]        occ
);

  logic [BDWORD-1:0] head, tail;

  assign dout = head;

  always_ff @(posedge clk) begin
    if (rst) occ <= 2'd0;
    else     occ <= occ + {1'b0, push} - {1'b0, pop};
  end

  // Data registers carry no reset; occ alone says what is valid.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      if (occ == 2'd2) begin
        head <= tail;
        tail <= din;
      end else begin
        head <= din;
      end
    end else if (push) begin
      if (occ == 2'd0) head <= din;
      else             tail <= din;
    end else if (pop) begin
      head <= tail;
    end
  end

endmodule

// File: rtl/ram_rd_streamer.sv
// Read-side initiator for ram_simple2port: walks (base, len, stride), issues RAM
// reads with 1-cycle latency and streams words out on valid/ready.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_base/cmd_len/cmd_stride   first address, word count, address step
//   busy                          command in progress
//   done                          1-cycle pulse after final word accepted
//   mem_rd_en/mem_rd_addr         RAM read request
//   mem_rd_word                   RAM read data, valid the cycle after mem_rd_en
//   out_valid/out_ready/out_word  output stream
module ram_rd_streamer
  import mvu_pkg::*;
#(
  parameter int BDADDR = BDADDR_DEF,
  parameter int BDWORD = BDWORD_DEF,
  parameter int BDLEN  = BDADDR + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BDADDR-1:0] cmd_base,
  input  logic [BDLEN-1:0]  cmd_len,
  input  logic [BDADDR-1:0] cmd_stride,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [BDADDR-1:0] mem_rd_addr,
  input  logic [BDWORD-1:0] mem_rd_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BDWORD-1:0] out_word
);

  state_t            state;
  logic [BDADDR-1:0] addr, stride;
  logic [BDLEN-1:0]  remaining;
  logic              inflight;
  logic [1:0]        occ;
  logic              pop, issue;
  logic [2:0]        used;

  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign out_valid   = (occ != 2'd0);
  assign pop         = out_valid & out_ready;

  // Credit: buffered words plus the word on its way back from the RAM must leave
  // room for this read. A same-cycle pop frees one slot.
  assign used        = {1'b0, occ} + {2'b0, inflight};
  assign issue       = (state == ST_RUN) && (remaining != '0) &&
                       (used < (3'd2 + {2'b0, pop}));
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      inflight  <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      stride    <= '0;
      remaining <= '0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_base;
            stride    <= cmd_stride;
            remaining <= cmd_len;
            if (cmd_len == '0) done  <= 1'b1;
            else               state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr      <= addr + stride;  // wraps mod 2**BDADDR
            remaining <= remaining - 1'b1;
            if (remaining == BDLEN'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Nothing in flight and the sole buffered word leaves now: it is the last.
          if (!inflight && occ == 2'd1 && pop) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  skid_fifo2 #(.BDWORD(BDWORD)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (mem_rd_word),
    .pop  (pop),
    .dout (out_word),
    .occ  (occ)
  );

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Self-checking bench for ram_rd_streamer with a behavioural RAM holding mem[i] = i.
module tb_ram_rd_streamer;
  localparam int BDADDR = 12;
  localparam int BDWORD = 32 * 64;
  localparam int BDLEN  = BDADDR + 1;

  logic              clk = 0, rst = 1;
  logic              cmd_valid = 0, cmd_ready;
  logic [BDADDR-1:0] cmd_base = '0, cmd_stride = '0;
  logic [BDLEN-1:0]  cmd_len = '0;
  logic              busy, done, mem_rd_en, out_valid, out_ready = 1;
  logic [BDADDR-1:0] mem_rd_addr;
  logic [BDWORD-1:0] mem_rd_word, out_word;

  ram_rd_streamer #(.BDADDR(BDADDR), .BDWORD(BDWORD), .BDLEN(BDLEN)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_word(mem_rd_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word)
  );

  always #5 clk = ~clk;

  // RAM model: mem[i] = i, one-cycle read latency, X when not reading.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_word <= BDWORD'(mem_rd_addr);
    else           mem_rd_word <= 'x;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // out_ready source: 0 = held high, 1 = random, 2 = held low
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard + monitor
  logic [63:0] exp_q[$];
  logic [63:0] addr_q[$];
  int          outstanding = 0;
  bit          prev_hold = 0;
  logic [63:0] prev_word;
  int          first_vld = -1, first_rd = -1, done_cyc = -1, n_rd = 0, n_done = 0;

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      prev_hold   = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", out_word[63:0], prev_word);
      end
      if (mem_rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        check("credit", 64'((outstanding - int'(out_valid & out_ready)) < 2), 64'd1);
        check("rd_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) check("rd_addr", 64'(mem_rd_addr), addr_q.pop_front());
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        check("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("word", out_word[63:0], exp_q.pop_front());
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      outstanding += int'(mem_rd_en) - int'(out_valid & out_ready);
      prev_hold = out_valid && !out_ready;
      prev_word = out_word[63:0];
    end
  end

  // Drive one command; acc returns the accept cycle index.
  task automatic issue_cmd(input int base, input int len, input int stride, output int acc);
    @(posedge clk); #1;
    check("cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1;
    cmd_base   = BDADDR'(base);
    cmd_len    = BDLEN'(len);
    cmd_stride = BDADDR'(stride);
    first_vld = -1; first_rd = -1; done_cyc = -1;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(64'((base + i * stride) % 4096));
      addr_q.push_back(64'((base + i * stride) % 4096));
    end
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    int n0 = n_done;
    int k  = 0;
    while (n_done == n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(n_done > n0), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_rd_en"},     64'(mem_rd_en), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n0, k;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_idle("reset");

    // 1: latency and throughput
    issue_cmd(5, 4, 1, c);
    wait_done(50);
    check("t1_first_rd", 64'(first_rd - c), 64'd1);
    check("t1_first_vld", 64'(first_vld - c), 64'd3);
    check("t1_done_cyc", 64'(done_cyc - c), 64'd7);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // 2: address wrap
    issue_cmd(4094, 4, 1, c);
    wait_done(50);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: stride with random backpressure
    rdy_mode = 1;
    issue_cmd(0, 8, 3, c);
    wait_done(300);
    check("t3_drained", 64'(exp_q.size()), 64'd0);
    rdy_mode = 0;

    // 4: zero length
    n0 = n_rd;
    issue_cmd(77, 0, 1, c);
    wait_done(20);
    repeat (3) @(negedge clk);
    check("t4_done_cyc", 64'(done_cyc - c), 64'd1);
    check("t4_no_reads", 64'(n_rd - n0), 64'd0);
    check("t4_no_valid", 64'(first_vld), 64'hFFFF_FFFF_FFFF_FFFF);

    // 5: stall mid-stream
    issue_cmd(100, 8, 1, c);
    k = 0;
    while (first_vld < 0 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1 rdy_mode = 2;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_outstanding", 64'(outstanding), 64'd2);
    check("t5_stalled_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1 rdy_mode = 0;
    wait_done(100);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // 6: reset mid-command, then a fresh command
    issue_cmd(200, 8, 1, c);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    exp_q.delete();
    addr_q.delete();
    n0 = n_done;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_idle("t6_reset");
    repeat (3) @(negedge clk);
    check("t6_no_done", 64'(n_done - n0), 64'd0);
    issue_cmd(10, 2, 1, c);
    wait_done(50);
    check("t6_done_cyc", 64'(done_cyc - c), 64'd5);
    check("t6_drained", 64'(exp_q.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
